// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC-source sequencer.
//   state_t  : sequencer FSM state encoding
//   cause_t  : exception cause codes as reported on exc_cause
//   PCSRC_*  : PC-source mux select encodings
//   encode_cause : fixed-priority exception encoder (opcode > ovf > div0)
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_FETCH_VEC,
    ST_LOAD_EXC,
    ST_LOAD_EPC,
    ST_LOAD_ALU
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } cause_t;

  localparam logic [1:0] PCSRC_EPC = 2'b00;
  localparam logic [1:0] PCSRC_ALU = 2'b01;
  localparam logic [1:0] PCSRC_EXC = 2'b10;

  function automatic cause_t encode_cause(input logic exc_opcode,
                                          input logic exc_ovf,
                                          input logic exc_div0);
    if (exc_opcode)    return CAUSE_OPCODE;
    else if (exc_ovf)  return CAUSE_OVF;
    else if (exc_div0) return CAUSE_DIV0;
    else               return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl.sv
// PC-source sequencer for the multicycle CPU.
// Takes redirect requests (exception, return-from-exception, branch/jump),
// saves EPC and fetches the handler vector byte on exceptions, then pulses
// pc_write with the matching PC-source select.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   exc_opcode/exc_ovf/exc_div0 exception request levels
//   rte_req, br_req            return-from-exception / branch request levels
//   mem_ack, mem_rdata         vector read completion and data byte
//   mem_req, mem_addr          vector read request and byte address
//   pc_src, pc_write           PC mux select and PC load strobe
//   epc_write                  EPC load strobe
//   exc_vec, exc_cause         captured handler address and cause
//   busy, done                 not-idle flag, PC-load-cycle pulse
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int VEC_OPCODE = 253,
  parameter int VEC_OVF    = 254,
  parameter int VEC_DIV0   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_opcode,
  input  logic              exc_ovf,
  input  logic              exc_div0,
  input  logic              rte_req,
  input  logic              br_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        pc_src,
  output logic              pc_write,
  output logic              epc_write,
  output logic [ADDR_W-1:0] exc_vec,
  output logic [1:0]        exc_cause,
  output logic              busy,
  output logic              done
);

  // Vector byte address for a given cause, zero-extended to the bus width.
  function automatic logic [ADDR_W-1:0] vec_addr(input cause_t cause);
    case (cause)
      CAUSE_OPCODE: return ADDR_W'(VEC_OPCODE);
      CAUSE_OVF:    return ADDR_W'(VEC_OVF);
      CAUSE_DIV0:   return ADDR_W'(VEC_DIV0);
      default:      return '0;
    endcase
  endfunction

  state_t              state, state_next;
  cause_t              cause_q, cause_next;
  logic [ADDR_W-1:0]   vec_q, vec_next;

  // Next-state logic. Requests only matter in IDLE; mem_ack only in FETCH_VEC.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    cause_next = cause_q;
    vec_next   = vec_q;
    case (state)
      ST_IDLE: begin
        if (exc_opcode || exc_ovf || exc_div0) begin
          cause_next = encode_cause(exc_opcode, exc_ovf, exc_div0);
          state_next = ST_SAVE_EPC;
        end else if (rte_req) begin
          state_next = ST_LOAD_EPC;
        end else if (br_req) begin
          state_next = ST_LOAD_ALU;
        end
      end
      ST_SAVE_EPC:  state_next = ST_FETCH_VEC;
      ST_FETCH_VEC: begin
        if (mem_ack) begin
          vec_next   = {{(ADDR_W-8){1'b0}}, mem_rdata};
          state_next = ST_LOAD_EXC;
        end
      end
      ST_LOAD_EXC,
      ST_LOAD_EPC,
      ST_LOAD_ALU:  state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // State and captured-data registers. Outputs are decoded from the next
  // state so they are flopped and line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      vec_q     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      pc_src    <= PCSRC_EPC;
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state     <= state_next;
      cause_q   <= cause_next;
      vec_q     <= vec_next;
      mem_req   <= (state_next == ST_FETCH_VEC);
      mem_addr  <= (state_next == ST_FETCH_VEC) ? vec_addr(cause_next) : '0;
      epc_write <= (state_next == ST_SAVE_EPC);
      busy      <= (state_next != ST_IDLE);
      case (state_next)
        ST_LOAD_EXC: begin pc_src <= PCSRC_EXC; pc_write <= 1'b1; done <= 1'b1; end
        ST_LOAD_EPC: begin pc_src <= PCSRC_EPC; pc_write <= 1'b1; done <= 1'b1; end
        ST_LOAD_ALU: begin pc_src <= PCSRC_ALU; pc_write <= 1'b1; done <= 1'b1; end
        default:     begin pc_src <= PCSRC_EPC; pc_write <= 1'b0; done <= 1'b0; end
      endcase
    end
  end

  assign exc_cause = cause_q;
  assign exc_vec   = vec_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl. Each request is run as a transaction
// whose per-cycle expected outputs are generated from the sequencing rules:
// a branch/RTE loads PC one cycle after sampling, an exception spends one
// cycle saving EPC, N+1 cycles requesting the vector, then loads PC.
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_ovf, exc_div0, rte_req, br_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  pc_src;
  logic        pc_write, epc_write;
  logic [31:0] exc_vec;
  logic [1:0]  exc_cause;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the architecturally visible captured values.
  logic [1:0]  m_cause = 2'b00;
  logic [31:0] m_vec   = 32'h0;

  pc_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .rte_req(rte_req), .br_req(br_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .pc_src(pc_src), .pc_write(pc_write), .epc_write(epc_write),
    .exc_vec(exc_vec), .exc_cause(exc_cause),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Request lines packed as {exc_opcode, exc_ovf, exc_div0, rte_req, br_req}.
  task automatic drive_reqs(input logic [4:0] r);
    {exc_opcode, exc_ovf, exc_div0, rte_req, br_req} = r;
  endtask

  task automatic chk_cycle(input string tag, input bit b, input bit d, input bit pw,
                           input bit epw, input bit mr, input logic [1:0] src,
                           input logic [31:0] addr);
    check({tag, ".flags"}, 64'({busy, done, pc_write, epc_write, mem_req}),
          64'({b, d, pw, epw, mr}));
    if (mr) check({tag, ".mem_addr"}, 64'(mem_addr), 64'(addr));
    if (pw) check({tag, ".pc_src"}, 64'(pc_src), 64'(src));
    check({tag, ".exc_cause"}, 64'(exc_cause), 64'(m_cause));
    check({tag, ".exc_vec"}, 64'(exc_vec), 64'(m_vec));
  endtask

  // Called at a negedge with the DUT idle. base: request levels presented
  // for sampling and held until done; extra: lines also raised while busy;
  // after: levels left on once done is seen; noise: random junk while busy.
  task automatic run_txn(input string tag, input logic [4:0] base, input logic [4:0] extra,
                         input logic [4:0] after, input int nwait,
                         input logic [7:0] rdata, input bit noise);
    logic [31:0] addr;
    logic [4:0]  busy_lines;
    drive_reqs(base);
    mem_ack = 1'b0;
    @(negedge clk);
    busy_lines = base | extra | (noise ? 5'($urandom) : 5'b0);
    if (base[4:2] != 3'b000) begin
      m_cause = base[4] ? 2'd1 : (base[3] ? 2'd2 : 2'd3);
      addr    = 32'(252 + int'(m_cause));
      chk_cycle({tag, ".save"}, 1, 0, 0, 1, 0, 2'b00, 32'h0);
      drive_reqs(busy_lines);
      mem_ack   = noise ? 1'($urandom) : 1'b0;
      mem_rdata = 8'($urandom);
      for (int i = 0; i <= nwait; i++) begin
        @(negedge clk);
        chk_cycle({tag, ".fetch"}, 1, 0, 0, 0, 1, 2'b00, addr);
        if (noise) drive_reqs(base | extra | 5'($urandom));
        mem_ack   = (i == nwait);
        mem_rdata = (i == nwait) ? rdata : 8'($urandom);
      end
      m_vec = {24'h0, rdata};
      @(negedge clk);
      chk_cycle({tag, ".load_exc"}, 1, 1, 1, 0, 0, 2'b10, 32'h0);
    end else if (base[1] || base[0]) begin
      chk_cycle({tag, ".load"}, 1, 1, 1, 0, 0, base[1] ? 2'b00 : 2'b01, 32'h0);
    end else begin
      chk_cycle({tag, ".idle"}, 0, 0, 0, 0, 0, 2'b00, 32'h0);
      return;
    end
    drive_reqs(after);
    mem_ack = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    chk_cycle({tag, ".back_idle"}, 0, 0, 0, 0, 0, 2'b00, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    drive_reqs(5'b0);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    check("reset.all", {busy, done, pc_write, epc_write, mem_req, pc_src, exc_cause,
                        mem_addr[7:0], exc_vec[7:0]}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    chk_cycle("post_reset", 0, 0, 0, 0, 0, 2'b00, 32'h0);

    // Directed scenarios.
    run_txn("br",     5'b00001, 5'b0, 5'b0, 0, 8'h00, 0);
    run_txn("rte",    5'b00010, 5'b0, 5'b0, 0, 8'h00, 0);
    run_txn("ovf",    5'b01000, 5'b0, 5'b0, 2, 8'h5A, 0);
    check("ovf.exc_vec", 64'(exc_vec), 64'h5A);
    check("ovf.exc_cause", 64'(exc_cause), 64'h2);
    // opcode + div0 + branch together: opcode wins, branch waits its turn.
    run_txn("prio",   5'b10101, 5'b0, 5'b00001, 1, 8'hC3, 0);
    run_txn("br_after", 5'b00001, 5'b0, 5'b0, 0, 8'h00, 0);
    check("persist.exc_cause", 64'(exc_cause), 64'h1);
    // div0 raised while ovf is in flight, still high afterwards.
    run_txn("nest_ovf", 5'b01000, 5'b00100, 5'b00100, 1, 8'h11, 0);
    run_txn("nest_div0", 5'b00100, 5'b0, 5'b0, 0, 8'h22, 0);
    run_txn("none",   5'b00000, 5'b0, 5'b0, 0, 8'h00, 0);

    // Reset in the middle of the vector fetch.
    drive_reqs(5'b01000);
    @(negedge clk);
    @(negedge clk);
    check("rst_seq.mem_req", 64'(mem_req), 64'h1);
    #2 reset = 1'b1;
    #1;
    m_cause = 2'b00;
    m_vec   = 32'h0;
    check("rst_async.all", {busy, done, pc_write, epc_write, mem_req, pc_src, exc_cause,
                            mem_addr, exc_vec[7:0]}, 64'h0);
    drive_reqs(5'b0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cycle("rst_abort", 0, 0, 0, 0, 0, 2'b00, 32'h0);
    end
    mem_ack = 1'b0;

    // Randomized transactions with bus noise while busy.
    for (int t = 0; t < 150; t++) begin
      logic [4:0] r;
      r = 5'($urandom);
      if ($urandom_range(0, 2) == 0) r[4:2] = 3'b000;
      run_txn("rand", r, 5'b0, 5'b0, $urandom_range(0, 5), 8'($urandom), 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
